// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the iterative CORDIC engine.
//   - MODE_ROTATE / MODE_VECTOR run-time mode encodings
//   - state_t FSM encoding
//   - ATAN_TAB: round(atan(2^-i) * 2^32 / 2pi) for i = 0..31
//   - atan_scaled(): table entry rescaled to a PH_BITS-wide phase, rounded
//   - GAIN_K / GAIN_SHIFT: 1/K as Q1.17 for optional gain compensation
package cordic_pkg;

  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_VECTOR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ITER,
    ST_GAIN,
    ST_DONE
  } state_t;

  localparam logic [31:0] ATAN_TAB [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  localparam int GAIN_K     = 79595;
  localparam int GAIN_SHIFT = 17;

  // Drop (32 - ph) LSBs with round-half-up; 33-bit intermediate keeps the carry.
  function automatic logic [31:0] atan_scaled(input logic [4:0] idx, input int ph);
    logic [32:0] v;
    int          sh;
    v  = {1'b0, ATAN_TAB[idx]};
    sh = 32 - ph;
    if (sh > 0) v = (v + (33'd1 << (sh - 1))) >> sh;
    return v[31:0];
  endfunction

endpackage

// File: rtl/cordic_iter_if.sv
// cordic_iter_if: input and output valid/ready channels of cordic_iter.
//   master: sample source / result consumer side
//   slave : engine side
//   input channel : i_valid, i_ready, i_mode, i_tag, x_i, y_i, z_i
//   output channel: o_valid, o_ready, o_mode, o_tag, x_o, y_o, z_o
interface cordic_iter_if #(
  parameter int XY_BITS  = 32,
  parameter int PH_BITS  = 32,
  parameter int TAG_BITS = 4
);
  logic                       i_valid;
  logic                       i_ready;
  logic                       i_mode;
  logic [TAG_BITS-1:0]        i_tag;
  logic signed [XY_BITS-1:0]  x_i;
  logic signed [XY_BITS-1:0]  y_i;
  logic signed [PH_BITS-1:0]  z_i;
  logic                       o_valid;
  logic                       o_ready;
  logic                       o_mode;
  logic [TAG_BITS-1:0]        o_tag;
  logic signed [XY_BITS+1:0]  x_o;
  logic signed [XY_BITS+1:0]  y_o;
  logic signed [PH_BITS-1:0]  z_o;

  modport master (
    output i_valid, i_mode, i_tag, x_i, y_i, z_i, o_ready,
    input  i_ready, o_valid, o_mode, o_tag, x_o, y_o, z_o
  );

  modport slave (
    input  i_valid, i_mode, i_tag, x_i, y_i, z_i, o_ready,
    output i_ready, o_valid, o_mode, o_tag, x_o, y_o, z_o
  );
endinterface

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational micro-rotation angle lookup.
//   idx  in  5        iteration index i
//   atan out PH_BITS  atan(2^-i) in phase units (2^PH_BITS = full turn)
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int PH_BITS = 32
) (
  input  logic [4:0]         idx,
  output logic [PH_BITS-1:0] atan
);
  logic [31:0] full;

  assign full = atan_scaled(idx, PH_BITS);
  assign atan = full[PH_BITS-1:0];
endmodule

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC, one shift/add step per clock, mode chosen
// per transaction (ROTATE or VECTOR), tag passed through.
//   clock  rising-edge clock
//   reset  asynchronous, active-high; aborts any transaction in flight
//   bus    cordic_iter_if.slave: input and output valid/ready channels
// Build option: CORDIC_GAIN_COMP_EN adds a GAIN state that scales x/y by
// 1/K (Q1.17 constant, round half-up) so result magnitude matches input.
module cordic_iter
  import cordic_pkg::*;
#(
  parameter int XY_BITS    = 32,
  parameter int PH_BITS    = 32,
  parameter int ITERATIONS = 24,
  parameter int TAG_BITS   = 4
) (
  input logic          clock,
  input logic          reset,
  cordic_iter_if.slave bus
);
  // Two guard bits cover sqrt(2) * K growth without overflow.
  localparam int W = XY_BITS + 2;

  generate
    if (ITERATIONS < 1 || ITERATIONS > PH_BITS - 1 || ITERATIONS > XY_BITS || PH_BITS > 32)
    begin : g_bad_cfg
      $error("cordic_iter: ITERATIONS must be 1..min(PH_BITS-1, XY_BITS) and PH_BITS <= 32");
    end
  endgenerate

  state_t                    state, state_nx;
  logic signed [W-1:0]       x, y, xs, ys;
  logic signed [PH_BITS-1:0] z;
  logic signed [PH_BITS-1:0] atan;
  logic [4:0]                cnt;
  logic                      mode;
  logic [TAG_BITS-1:0]       tag;
  logic                      d_pos;

  cordic_atan_lut #(.PH_BITS(PH_BITS)) u_lut (.idx(cnt), .atan(atan));

  assign xs    = x >>> cnt;
  assign ys    = y >>> cnt;
  // ROTATE drives z to 0; VECTOR drives y to 0.
  assign d_pos = (mode == MODE_VECTOR) ? y[W-1] : ~z[PH_BITS-1];

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [GAIN_SHIFT:0]  GK  = (GAIN_SHIFT + 1)'(GAIN_K);
  localparam logic signed [W+GAIN_SHIFT:0] RND = (W + GAIN_SHIFT + 1)'(1) <<< (GAIN_SHIFT - 1);
  logic signed [W+GAIN_SHIFT:0] xp, yp;
  logic signed [W-1:0]          xg, yg;

  assign xp = x * GK + RND;
  assign yp = y * GK + RND;
  assign xg = W'(xp >>> GAIN_SHIFT);
  assign yg = W'(yp >>> GAIN_SHIFT);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.i_valid) state_nx = ST_PRE;
      ST_PRE:  state_nx = ST_ITER;
      ST_ITER:
        if (cnt == 5'(ITERATIONS - 1))
`ifdef CORDIC_GAIN_COMP_EN
          state_nx = ST_GAIN;
`else
          state_nx = ST_DONE;
`endif
      ST_GAIN: state_nx = ST_DONE;
      ST_DONE: if (bus.o_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      cnt  <= '0;
      mode <= MODE_ROTATE;
      tag  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.i_valid) begin
          x    <= {{2{bus.x_i[XY_BITS-1]}}, bus.x_i};
          y    <= {{2{bus.y_i[XY_BITS-1]}}, bus.y_i};
          z    <= bus.z_i;
          mode <= bus.i_mode;
          tag  <= bus.i_tag;
        end
        ST_PRE: begin
          cnt <= '0;
          if (mode == MODE_ROTATE) begin
            // |z| >= 90 deg: pre-rotate by 180 deg (adding 2^(PH-1) flips the MSB).
            if (z[PH_BITS-1] ^ z[PH_BITS-2]) begin
              x <= -x;
              y <= -y;
              z[PH_BITS-1] <= ~z[PH_BITS-1];
            end
          end else if (x[W-1]) begin
            x <= -x;
            y <= -y;
            z <= {1'b1, {(PH_BITS-1){1'b0}}};
          end else begin
            z <= '0;
          end
        end
        ST_ITER: begin
          if (d_pos) begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan;
          end else begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan;
          end
          cnt <= cnt + 5'd1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          x <= xg;
          y <= yg;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.i_ready = (state == ST_IDLE) && !reset;
  assign bus.o_valid = (state == ST_DONE);
  assign bus.o_mode  = mode;
  assign bus.o_tag   = tag;
  assign bus.x_o     = x;
  assign bus.y_o     = y;
  assign bus.z_o     = z;

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: directed + randomized bench for cordic_iter. Expected
// results come from a floating-point rotation / atan2 model scaled by the
// CORDIC gain of the configured build.
module tb_cordic_iter;
  localparam int  XY = 32, PH = 32, N = 24, TB = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  COMP = 1;
`else
  localparam int  COMP = 0;
`endif
  localparam int  LAT    = N + 1 + COMP;
  localparam int  PERIOD = N + 3 + COMP;
  localparam int  TOL_XY = 400;
  localparam int  TOL_Z  = 512;
  localparam real PI     = 3.14159265358979323846;
  localparam real TURN   = 4294967296.0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0, failures = 0, cyc = 0;
  real  gain;

  cordic_iter_if #(.XY_BITS(XY), .PH_BITS(PH), .TAG_BITS(TB)) bus();

  cordic_iter #(.XY_BITS(XY), .PH_BITS(PH), .ITERATIONS(N), .TAG_BITS(TB)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_eq(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint obs, input real exp, input int tol);
    real d;
    d = real'(obs) - exp;
    if (d < 0.0) d = -d;
    checks++;
    assert (d <= real'(tol)) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0.1f (tol %0d)", nm, obs, exp, tol);
    end
  endtask

  // Phase compare modulo one full turn.
  task automatic chk_ph(input string nm, input logic [31:0] obs, input real exp, input int tol);
    longint d;
    d = longint'($signed(obs)) - longint'(exp);
    d = ((d + 64'sd6442450944) % 64'sd4294967296) - 64'sd2147483648;
    if (d < 0) d = -d;
    checks++;
    assert (d <= longint'(tol)) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0.1f (tol %0d)", nm, obs, exp, tol);
    end
  endtask

  task automatic model(input bit m, input longint x, input longint y, input logic [31:0] z,
                       output real xe, output real ye, output real ze);
    real th;
    if (m == 1'b0) begin
      th = real'(longint'($signed(z))) * 2.0 * PI / TURN;
      xe = gain * (real'(x) * $cos(th) - real'(y) * $sin(th));
      ye = gain * (real'(x) * $sin(th) + real'(y) * $cos(th));
      ze = 0.0;
    end else begin
      xe = gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      ye = 0.0;
      ze = $atan2(real'(y), real'(x)) * TURN / (2.0 * PI);
    end
  endtask

  task automatic drive(input bit m, input logic [3:0] t, input longint x, input longint y,
                       input logic [31:0] z);
    bus.i_mode = m;
    bus.i_tag  = t;
    bus.x_i    = 32'(x);
    bus.y_i    = 32'(y);
    bus.z_i    = z;
  endtask

  task automatic send(output int e);
    e = -1;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (bus.i_ready) begin
        tick();
        e = cyc;
        break;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    checks++;
    assert (e >= 0) else begin
      failures++;
      $error("FAIL accept_timeout: got no handshake expected one within 200 cycles");
    end
  endtask

  task automatic wait_valid(output int v);
    v = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus.o_valid) begin
        v = cyc;
        break;
      end
      tick();
    end
    checks++;
    assert (v >= 0) else begin
      failures++;
      $error("FAIL valid_timeout: got no o_valid expected one within 200 cycles");
    end
  endtask

  task automatic check_out(input string nm, input bit m, input logic [3:0] t,
                           input longint x, input longint y, input logic [31:0] z);
    real xe, ye, ze;
    model(m, x, y, z, xe, ye, ze);
    chk_eq({nm, ".mode"}, 64'(bus.o_mode), 64'(m));
    chk_eq({nm, ".tag"}, 64'(bus.o_tag), 64'(t));
    chk_tol({nm, ".x"}, longint'(bus.x_o), xe, TOL_XY);
    chk_tol({nm, ".y"}, longint'(bus.y_o), ye, TOL_XY);
    chk_ph({nm, ".z"}, bus.z_o, ze, TOL_Z);
  endtask

  task automatic finish_out(input string nm);
    bus.o_ready = 1'b1;
    tick();
    chk_eq({nm, ".hs_i_ready"}, 64'(bus.i_ready), 64'd1);
    chk_eq({nm, ".hs_o_valid"}, 64'(bus.o_valid), 64'd0);
    bus.o_ready = 1'b0;
  endtask

  task automatic run_one(input string nm, input bit m, input logic [3:0] t,
                         input longint x, input longint y, input logic [31:0] z);
    int e, v;
    drive(m, t, x, y, z);
    send(e);
    wait_valid(v);
    chk_eq({nm, ".latency"}, 64'(v - e), 64'(LAT));
    check_out(nm, m, t, x, y, z);
    finish_out(nm);
  endtask

  task automatic rnd_xy(output longint x, output longint y);
    do begin
      x = longint'($urandom_range(32'd1073741824, 32'd0)) - 64'sd536870912;
      y = longint'($urandom_range(32'd1073741824, 32'd0)) - 64'sd536870912;
    end while (x * x + y * y < 64'sd72057594037927936);
  endtask

  initial begin
    int          e, v, hits, r, k, prev_v;
    logic        rdy;
    longint      rx, ry;
    real         xe, ye, ze;
    bit          bm [4];
    logic [3:0]  bt [4];
    longint      bx [4], by [4];
    logic [31:0] bz [4];

    gain = 1.0;
    for (int i = 0; i < N; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
    if (COMP == 1) gain = gain * 79595.0 / 131072.0;

    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;
    drive(1'b0, 4'd0, 0, 0, 32'd0);

    // Reset state
    tick();
    tick();
    chk_eq("rst.i_ready", 64'(bus.i_ready), 64'd0);
    chk_eq("rst.o_valid", 64'(bus.o_valid), 64'd0);
    chk_eq("rst.x_o", 64'(bus.x_o), 64'd0);
    chk_eq("rst.y_o", 64'(bus.y_o), 64'd0);
    chk_eq("rst.z_o", 64'(bus.z_o), 64'd0);
    chk_eq("rst.o_tag", 64'(bus.o_tag), 64'd0);
    chk_eq("rst.o_mode", 64'(bus.o_mode), 64'd0);
    reset = 1'b0;
    tick();
    chk_eq("rst.release_i_ready", 64'(bus.i_ready), 64'd1);

    // 45 degree rotation with backpressure on the result
    drive(1'b0, 4'h5, 64'sd536870912, 0, 32'h20000000);
    send(e);
    wait_valid(v);
    chk_eq("rot45.latency", 64'(v - e), 64'(LAT));
    check_out("rot45", 1'b0, 4'h5, 64'sd536870912, 0, 32'h20000000);
    model(1'b0, 64'sd536870912, 0, 32'h20000000, xe, ye, ze);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("bp.o_valid", 64'(bus.o_valid), 64'd1);
      chk_eq("bp.i_ready", 64'(bus.i_ready), 64'd0);
      chk_eq("bp.o_tag", 64'(bus.o_tag), 64'h5);
      chk_tol("bp.x", longint'(bus.x_o), xe, TOL_XY);
      chk_tol("bp.y", longint'(bus.y_o), ye, TOL_XY);
    end
    finish_out("rot45");

    // Rotation beyond 90 degrees (PRE half-turn), then vectoring cases
    run_one("rot_m170", 1'b0, 4'h1, 64'sd536870912, 0, 32'h871C71C7);
    run_one("vec_negx", 1'b1, 4'h2, -64'sd268435456, 0, 32'h12345678);
    run_one("vec_y90",  1'b1, 4'h3, 0, 64'sd268435456, 32'h0);

    // Randomized transactions
    for (int i = 0; i < 6; i++) begin
      rnd_xy(rx, ry);
      run_one($sformatf("rnd%0d", i), 1'(i % 2), 4'($urandom_range(15, 0)), rx, ry, 32'($urandom));
    end

    // Reset while iterating: transaction is lost, outputs cleared
    drive(1'b0, 4'hA, 64'sd300000000, 64'sd100000000, 32'h10000000);
    send(e);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    chk_eq("midrst.o_valid", 64'(bus.o_valid), 64'd0);
    chk_eq("midrst.i_ready", 64'(bus.i_ready), 64'd0);
    chk_eq("midrst.x_o", 64'(bus.x_o), 64'd0);
    chk_eq("midrst.z_o", 64'(bus.z_o), 64'd0);
    chk_eq("midrst.o_tag", 64'(bus.o_tag), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_eq("midrst.release_i_ready", 64'(bus.i_ready), 64'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_valid) hits++;
      tick();
    end
    chk_eq("midrst.no_valid", 64'(hits), 64'd0);
    chk_eq("midrst.y_o", 64'(bus.y_o), 64'd0);

    // Back-to-back with i_valid held high and o_ready high
    for (int i = 0; i < 4; i++) begin
      rnd_xy(rx, ry);
      bm[i] = 1'(i % 2);
      bt[i] = 4'(i);
      bx[i] = rx;
      by[i] = ry;
      bz[i] = 32'($urandom);
    end
    drive(bm[0], bt[0], bx[0], by[0], bz[0]);
    bus.i_valid = 1'b1;
    bus.o_ready = 1'b1;
    k = 0;
    r = 0;
    prev_v = 0;
    for (int c = 0; c < 400 && r < 4; c++) begin
      rdy = bus.i_ready;
      tick();
      if (rdy && bus.i_valid) begin
        k++;
        if (k < 4) drive(bm[k], bt[k], bx[k], by[k], bz[k]);
        else bus.i_valid = 1'b0;
      end
      if (bus.o_valid) begin
        check_out($sformatf("b2b%0d", r), bm[r], bt[r], bx[r], by[r], bz[r]);
        if (r > 0) chk_eq("b2b.spacing", 64'(cyc - prev_v), 64'(PERIOD));
        prev_v = cyc;
        r++;
      end
    end
    chk_eq("b2b.count", 64'(r), 64'd4);
    bus.i_valid = 1'b0;
    tick();
    bus.o_ready = 1'b0;
    tick();
    chk_eq("b2b.idle_i_ready", 64'(bus.i_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
